dlfloat_operand_loader: RTL and testbench

Upstream stage of the DLFloat16 MAC. Accepts a byte-serial operand stream (high byte first), assembles it into 16-bit operand pairs (A, B), tags special values, and buffers the pairs in a small FIFO. Pairs are then issued to the MAC over a valid/ready handshake. The loader replaces free-running two-phase capture with flow-controlled loading, so no operand pair is dropped or mis-paired while the MAC is stalled.

---
 rtl/dlfloat_operand_loader.sv | 74 +++++++
 tb/tb_dlfloat_operand_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_operand_loader.sv
// dlfloat_operand_loader: byte-serial DLFloat16 operand pair assembler with tagging and an issue FIFO.
module dlfloat_operand_loader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  output logic [15:0]                   op_a,
  output logic [15:0]                   op_b,
  output logic [1:0]                    op_special,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pair_count,
  output logic                          nan_seen
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {AH, AL, BH, BL} state_t;
  state_t state, state_next;
  logic [15:0] a, b;
  logic [7:0] bh;
  logic [1:0] tag;
  logic [33:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] level;
  logic full, xfer, push, pop;
  // full comes from registered level only, keeping op_ready off the byte_ready path
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign byte_ready = state != BL || !full;
  assign xfer = byte_valid && byte_ready;
  assign push = xfer && state == BL;
  assign op_valid = level != '0;
  assign pop = op_valid && op_ready;
  assign b = {bh, byte_in};
  assign tag = {a == 16'hFFFF || b == 16'hFFFF, a == 16'h0000 || b == 16'h0000};
  assign {op_special, op_a, op_b} = op_valid ? mem[rd] : '0;
  assign fifo_level = level;
  always_comb
    state_next = flush ? AH : !xfer ? state :
                 state == AH ? AL : state == AL ? BH : state == BH ? BL : AH;
  always_ff @(posedge clk)
    if (rst) state <= AH;
    else state <= state_next;
  always_ff @(posedge clk)
    if (!rst && !flush && push) mem[wr] <= {tag, a, b};
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      bh <= '0;
      rd <= '0;
      wr <= '0;
      level <= '0;
      pair_count <= '0;
      nan_seen <= 1'b0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      level <= '0;
      nan_seen <= 1'b0;
    end else begin
      if (xfer && state == AH) a[15:8] <= byte_in;
      if (xfer && state == AL) a[7:0] <= byte_in;
      if (xfer && state == BH) bh <= byte_in;
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      if (pop) pair_count <= pair_count + 16'd1;
      nan_seen <= nan_seen | (push & tag[1]);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// tb_dlfloat_operand_loader: directed and random checks against a queue-based reference model.
module tb_dlfloat_operand_loader;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, flush = 0, byte_valid = 0, op_ready = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, op_valid, nan_seen;
  logic [15:0] op_a, op_b, pair_count;
  logic [1:0] op_special;
  logic [$clog2(DEPTH):0] fifo_level;
  int total = 0, bad = 0;
  int nb = 0;
  logic [7:0] bq [3];
  logic [33:0] fq [$];
  logic [15:0] pc = 0;
  logic nan = 0;

  dlfloat_operand_loader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .op_a(op_a), .op_b(op_b), .op_special(op_special),
    .op_valid(op_valid), .op_ready(op_ready), .fifo_level(fifo_level),
    .pair_count(pair_count), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  function automatic bit model_br();
    return !(nb == 3 && fq.size() == DEPTH);
  endfunction

  // advances one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    bit xf, pp;
    logic [15:0] a, b;
    xf = byte_valid && model_br();
    pp = fq.size() != 0 && op_ready;
    @(posedge clk);
    if (rst) begin
      nb = 0; fq.delete(); pc = 0; nan = 0;
    end else if (flush) begin
      nb = 0; fq.delete(); nan = 0;
    end else begin
      if (pp) begin
        void'(fq.pop_front());
        pc = pc + 16'd1;
      end
      if (xf) begin
        if (nb < 3) begin
          bq[nb] = byte_in;
          nb++;
        end else begin
          a = {bq[0], bq[1]};
          b = {bq[2], byte_in};
          fq.push_back({a == 16'hFFFF || b == 16'hFFFF, a == 16'h0 || b == 16'h0, a, b});
          if (a == 16'hFFFF || b == 16'hFFFF) nan = 1;
          nb = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    int n = 0;
    byte_valid = 1;
    byte_in = v;
    while (!model_br() && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n == 50) begin
      bad++;
      $display("FAIL send_byte timeout byte_ready=%0b required=1", byte_ready);
    end
    tick();
    byte_valid = 0;
  endtask

  task automatic send_pair(input logic [31:0] p);
    for (int i = 3; i >= 0; i--) send_byte(p[i*8 +: 8]);
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    total++;
    if ({byte_ready, op_valid, op_a, op_b, op_special, fifo_level, pair_count, nan_seen} !==
        {1'b1, 1'b0, 16'h0, 16'h0, 2'b0, 3'd0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset got br=%b v=%b a=%h b=%h s=%b lvl=%0d pc=%0d nan=%b required 1 0 0 0 0 0 0 0",
               byte_ready, op_valid, op_a, op_b, op_special, fifo_level, pair_count, nan_seen);
    end
  endtask

  task automatic test_basic();
    send_pair(32'h3E003E00);
    total++;
    if ({op_valid, op_a, op_b, op_special, fifo_level} !== {1'b1, 16'h3E00, 16'h3E00, 2'b00, 3'd1}) begin
      bad++;
      $display("FAIL basic_issue got v=%b a=%h b=%h s=%b lvl=%0d required 1 3e00 3e00 00 1",
               op_valid, op_a, op_b, op_special, fifo_level);
    end
    op_ready = 1;
    tick();
    op_ready = 0;
    total++;
    if ({pair_count, op_valid} !== {16'd1, 1'b0}) begin
      bad++;
      $display("FAIL basic_pop got pc=%0d v=%b required 1 0", pair_count, op_valid);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    op_ready = 0;
    for (int i = 0; i < DEPTH; i++) send_pair($urandom);
    total++;
    if (fifo_level !== 3'(DEPTH)) begin
      bad++;
      $display("FAIL stall_level got %0d required %0d", fifo_level, DEPTH);
    end
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    byte_valid = 1;
    byte_in = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (byte_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_byte_ready got %b required 0", byte_ready);
      end
      tick();
    end
    total++;
    if ({op_a, op_b} !== fq[0][31:0]) begin
      bad++;
      $display("FAIL stall_head got %h required %h", {op_a, op_b}, fq[0][31:0]);
    end
    op_ready = 1;
    tick();
    op_ready = 0;
    total++;
    if ({byte_ready, fifo_level} !== {1'b1, 3'(DEPTH - 1)}) begin
      bad++;
      $display("FAIL stall_release got br=%b lvl=%0d required 1 %0d", byte_ready, fifo_level, DEPTH - 1);
    end
    tick();
    byte_valid = 0;
    total++;
    if (fifo_level !== 3'(DEPTH)) begin
      bad++;
      $display("FAIL stall_accept got %0d required %0d", fifo_level, DEPTH);
    end
    op_ready = 1;
    while (fq.size() != 0 && n < 20) begin
      total++;
      if ({op_valid, op_special, op_a, op_b} !== {1'b1, fq[0]}) begin
        bad++;
        $display("FAIL stall_drain got %b %h required 1 %h", op_valid, {op_special, op_a, op_b}, fq[0]);
      end
      tick();
      n++;
    end
    op_ready = 0;
  endtask

  task automatic test_special();
    send_pair(32'h00004123);
    total++;
    if (op_special !== 2'b01) begin
      bad++;
      $display("FAIL special_zero got %b required 01", op_special);
    end
    op_ready = 1;
    tick();
    op_ready = 0;
    send_pair(32'hFFFF4000);
    total++;
    if ({op_special, nan_seen} !== {2'b10, 1'b1}) begin
      bad++;
      $display("FAIL special_nan got s=%b nan=%b required 10 1", op_special, nan_seen);
    end
    flush = 1;
    tick();
    flush = 0;
    total++;
    if ({nan_seen, pair_count, op_valid} !== {1'b0, pc, 1'b0}) begin
      bad++;
      $display("FAIL flush_nan got nan=%b pc=%0d v=%b required 0 %0d 0", nan_seen, pair_count, op_valid, pc);
    end
  endtask

  task automatic test_flush_mid();
    send_byte(8'hAA);
    send_byte(8'hBB);
    flush = 1;
    tick();
    flush = 0;
    send_pair(32'h12345678);
    total++;
    if ({op_valid, op_a, op_b} !== {1'b1, 16'h1234, 16'h5678}) begin
      bad++;
      $display("FAIL flush_mid got v=%b a=%h b=%h required 1 1234 5678", op_valid, op_a, op_b);
    end
    op_ready = 1;
    tick();
    op_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pc0;
    send_pair($urandom);
    send_pair($urandom);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    byte_valid = 1;
    byte_in = 8'($urandom);
    op_ready = 1;
    tick();
    byte_valid = 0;
    op_ready = 0;
    total++;
    if ({fifo_level, op_special, op_a, op_b} !== {3'd2, fq[0]}) begin
      bad++;
      $display("FAIL b2b got lvl=%0d head=%h required 2 %h", fifo_level, {op_special, op_a, op_b}, fq[0]);
    end
    pc0 = pc;
    flush = 1;
    op_ready = 1;
    tick();
    flush = 0;
    op_ready = 0;
    total++;
    if ({fifo_level, pair_count, op_valid} !== {3'd0, pc0, 1'b0}) begin
      bad++;
      $display("FAIL flush_pop got lvl=%0d pc=%0d v=%b required 0 %0d 0", fifo_level, pair_count, op_valid, pc0);
    end
  endtask

  task automatic test_wrap_and_reset();
    send_pair($urandom);
    force dut.pair_count = 16'hFFFF;
    #1;
    release dut.pair_count;
    pc = 16'hFFFF;
    op_ready = 1;
    tick();
    op_ready = 0;
    total++;
    if (pair_count !== 16'h0000) begin
      bad++;
      $display("FAIL wrap got %h required 0000", pair_count);
    end
    send_pair($urandom);
    send_pair(32'hFFFF0001);
    send_byte(8'h55);
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({byte_ready, op_valid, op_a, op_b, op_special, fifo_level, pair_count, nan_seen} !==
        {1'b1, 1'b0, 16'h0, 16'h0, 2'b0, 3'd0, 16'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got br=%b v=%b a=%h b=%h s=%b lvl=%0d pc=%0d nan=%b required 1 0 0 0 0 0 0 0",
               byte_ready, op_valid, op_a, op_b, op_special, fifo_level, pair_count, nan_seen);
    end
    send_pair(32'hCAFE0102);
    total++;
    if ({op_a, op_b} !== 32'hCAFE0102) begin
      bad++;
      $display("FAIL post_reset_pair got %h required cafe0102", {op_a, op_b});
    end
  endtask

  task automatic test_random();
    logic [33:0] h;
    for (int c = 0; c < 600; c++) begin
      byte_valid = $urandom_range(0, 3) != 0;
      byte_in = 8'($urandom_range(0, 7) == 0 ? 8'hFF : $urandom_range(0, 7) == 0 ? 8'h00 : $urandom);
      op_ready = $urandom_range(0, 2) == 0;
      flush = $urandom_range(0, 59) == 0;
      h = fq.size() != 0 ? fq[0] : '0;
      total++;
      if ({byte_ready, op_valid, op_special, op_a, op_b, fifo_level, pair_count, nan_seen} !==
          {model_br(), fq.size() != 0, h, 3'(fq.size()), pc, nan}) begin
        bad++;
        $display("FAIL random cyc=%0d got br=%b v=%b head=%h lvl=%0d pc=%0d nan=%b required %b %b %h %0d %0d %b",
                 c, byte_ready, op_valid, {op_special, op_a, op_b}, fifo_level, pair_count, nan_seen,
                 model_br(), fq.size() != 0, h, fq.size(), pc, nan);
      end
      tick();
    end
    byte_valid = 0;
    op_ready = 0;
    flush = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_special();
    test_flush_mid();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
